// File: rtl/pt_pkg.sv
// Shared types and default sizing for the per-channel packet tracker.
package pt_pkg;

  typedef enum logic {
    PT_IDLE = 1'b0,
    PT_BODY = 1'b1
  } pt_state_e;

  localparam int unsigned PT_LEN_W     = 3;
  localparam int unsigned PT_FIXED_LEN = 4;

endpackage

// File: rtl/pt_channel.sv
// One channel of the packet tracker: counts flits of the packet in progress,
// flags the tail flit, pulses on packet end and keeps a sticky length error.
module pt_channel
  import pt_pkg::*;
#(
  parameter int unsigned LEN_W     = PT_LEN_W,
  parameter int unsigned FIXED_LEN = PT_FIXED_LEN,
  parameter int unsigned VAR_LEN   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  input  logic             flush,
  input  logic             err_clr,
  output logic             empty,
  output logic             tail,
  output logic             pkt_end,
  output logic [LEN_W-1:0] cnt,
  output logic             err
);

  pt_state_e        state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_eff;
  logic             len_zero;
  logic             end_q, end_d;
  logic             err_q, err_d;
  logic             err_set;

  // Effective length of a packet whose head flit is offered this cycle.
  always_comb begin
    len_zero = 1'b0;
    len_eff  = LEN_W'(FIXED_LEN);
    if (VAR_LEN != 0) begin
      len_zero = (len == '0);
      len_eff  = len_zero ? LEN_W'(1) : len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PT_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  // Flush takes priority over a flit offered in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    end_d   = 1'b0;
    err_set = 1'b0;
    if (flush) begin
      state_d = PT_IDLE;
      cnt_d   = '0;
      len_d   = '0;
    end else if (inc) begin
      if (state_q == PT_IDLE) begin
        err_set = len_zero;
        if (len_eff == LEN_W'(1)) begin
          end_d = 1'b1;
        end else begin
          state_d = PT_BODY;
          cnt_d   = LEN_W'(1);
          len_d   = len_eff;
        end
      end else begin
        if (cnt_q + LEN_W'(1) == len_q) begin
          state_d = PT_IDLE;
          cnt_d   = '0;
          len_d   = '0;
          end_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
    end
    err_d = err_set | (err_q & ~err_clr);
  end

  assign empty   = (state_q == PT_IDLE);
  assign tail    = ((state_q == PT_IDLE) && (len_eff == LEN_W'(1))) ||
                   ((state_q == PT_BODY) && (cnt_q == len_q - LEN_W'(1)));
  assign pkt_end = end_q;
  assign cnt     = cnt_q;
  assign err     = err_q;

endmodule

// File: rtl/packet_tracker_mc.sv
// Multi-channel packet tracker: NUM_CH independent flit counters with
// tail/end indication and sticky header-length errors.
module packet_tracker_mc
  import pt_pkg::*;
#(
  parameter int unsigned NUM_CH    = 5,
  parameter int unsigned LEN_W     = PT_LEN_W,
  parameter int unsigned FIXED_LEN = PT_FIXED_LEN,
  parameter int unsigned VAR_LEN   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       pt_inc_i,
  input  logic [NUM_CH*LEN_W-1:0] pt_len_i,
  input  logic [NUM_CH-1:0]       pt_flush_i,
  input  logic                    pt_err_clr_i,
  output logic [NUM_CH-1:0]       pt_empty_o,
  output logic [NUM_CH-1:0]       pt_tail_o,
  output logic [NUM_CH-1:0]       pt_end_o,
  output logic [NUM_CH*LEN_W-1:0] pt_cnt_o,
  output logic [NUM_CH-1:0]       pt_err_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pt_channel #(
      .LEN_W     (LEN_W),
      .FIXED_LEN (FIXED_LEN),
      .VAR_LEN   (VAR_LEN)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (pt_inc_i[c]),
      .len     (pt_len_i[c*LEN_W +: LEN_W]),
      .flush   (pt_flush_i[c]),
      .err_clr (pt_err_clr_i),
      .empty   (pt_empty_o[c]),
      .tail    (pt_tail_o[c]),
      .pkt_end (pt_end_o[c]),
      .cnt     (pt_cnt_o[c*LEN_W +: LEN_W]),
      .err     (pt_err_o[c])
    );
  end

endmodule

// File: tb/tb_packet_tracker_mc.sv
// Bench for packet_tracker_mc: a fixed-length and a variable-length instance
// checked against a remaining-flits model, a vector table and directed cases.
module tb_packet_tracker_mc;
  localparam int unsigned NUM_CH    = 5;
  localparam int unsigned LEN_W     = 3;
  localparam int unsigned FIXED_LEN = 4;
  localparam int unsigned ND        = 2;  // 0: fixed length, 1: header length

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]       incv   [ND];
  logic [NUM_CH-1:0]       flushv [ND];
  logic [NUM_CH*LEN_W-1:0] lenv   [ND];
  logic                    clrv   [ND];
  logic [NUM_CH-1:0]       o_empty[ND];
  logic [NUM_CH-1:0]       o_tail [ND];
  logic [NUM_CH-1:0]       o_end  [ND];
  logic [NUM_CH*LEN_W-1:0] o_cnt  [ND];
  logic [NUM_CH-1:0]       o_err  [ND];

  logic [NUM_CH-1:0]       f_empty, f_tail, f_end, f_err, v_empty, v_tail, v_end, v_err;
  logic [NUM_CH*LEN_W-1:0] f_cnt, v_cnt;

  packet_tracker_mc #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .FIXED_LEN(FIXED_LEN), .VAR_LEN(0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .pt_inc_i(incv[0]), .pt_len_i(lenv[0]), .pt_flush_i(flushv[0]),
    .pt_err_clr_i(clrv[0]), .pt_empty_o(f_empty), .pt_tail_o(f_tail), .pt_end_o(f_end),
    .pt_cnt_o(f_cnt), .pt_err_o(f_err));

  packet_tracker_mc #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .FIXED_LEN(FIXED_LEN), .VAR_LEN(1)) dut_var (
    .clk(clk), .rst_n(rst_n), .pt_inc_i(incv[1]), .pt_len_i(lenv[1]), .pt_flush_i(flushv[1]),
    .pt_err_clr_i(clrv[1]), .pt_empty_o(v_empty), .pt_tail_o(v_tail), .pt_end_o(v_end),
    .pt_cnt_o(v_cnt), .pt_err_o(v_err));

  assign o_empty[0] = f_empty;  assign o_empty[1] = v_empty;
  assign o_tail[0]  = f_tail;   assign o_tail[1]  = v_tail;
  assign o_end[0]   = f_end;    assign o_end[1]   = v_end;
  assign o_cnt[0]   = f_cnt;    assign o_cnt[1]   = v_cnt;
  assign o_err[0]   = f_err;    assign o_err[1]   = v_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: flits still owed by the packet in progress (0 = no packet).
  int m_rem [ND][NUM_CH];
  int m_cnt [ND][NUM_CH];
  bit m_end [ND][NUM_CH];
  bit m_err [ND][NUM_CH];

  function automatic int fld(int d, int c);
    return int'(lenv[d][c*LEN_W +: LEN_W]);
  endfunction

  function automatic int eff_len(int d, int c);
    if (d == 0) return FIXED_LEN;
    return (fld(d, c) == 0) ? 1 : fld(d, c);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < NUM_CH; c++) begin
        m_rem[d][c] = 0; m_cnt[d][c] = 0; m_end[d][c] = 0; m_err[d][c] = 0;
      end
  endtask

  task automatic model_update(input int d);
    for (int c = 0; c < NUM_CH; c++) begin
      bit new_err = 0;
      bit new_end = 0;
      if (flushv[d][c]) begin
        m_rem[d][c] = 0;
        m_cnt[d][c] = 0;
      end else if (incv[d][c]) begin
        if (m_rem[d][c] == 0) begin
          new_err = (d == 1) && (fld(d, c) == 0);
          if (eff_len(d, c) == 1) new_end = 1;
          else begin
            m_rem[d][c] = eff_len(d, c) - 1;
            m_cnt[d][c] = 1;
          end
        end else begin
          m_rem[d][c]--;
          m_cnt[d][c]++;
          if (m_rem[d][c] == 0) begin
            m_cnt[d][c] = 0;
            new_end = 1;
          end
        end
      end
      m_end[d][c] = new_end;
      m_err[d][c] = new_err ? 1'b1 : (clrv[d] ? 1'b0 : m_err[d][c]);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      logic [NUM_CH-1:0]       ee, et, en, er;
      logic [NUM_CH*LEN_W-1:0] ec;
      for (int c = 0; c < NUM_CH; c++) begin
        ee[c] = (m_rem[d][c] == 0);
        et[c] = (m_rem[d][c] == 1) || ((m_rem[d][c] == 0) && (eff_len(d, c) == 1));
        en[c] = m_end[d][c];
        er[c] = m_err[d][c];
        ec[c*LEN_W +: LEN_W] = LEN_W'(m_cnt[d][c]);
      end
      chk($sformatf("m%0d_empty", d), 32'(o_empty[d]), 32'(ee));
      chk($sformatf("m%0d_tail", d),  32'(o_tail[d]),  32'(et));
      chk($sformatf("m%0d_end", d),   32'(o_end[d]),   32'(en));
      chk($sformatf("m%0d_err", d),   32'(o_err[d]),   32'(er));
      chk($sformatf("m%0d_cnt", d),   32'(o_cnt[d]),   32'(ec));
    end
  endtask

  // Inputs are set at posedge+1; checked mid-cycle; model advances on the edge.
  task automatic cycle();
    #3;
    check_all();
    @(posedge clk);
    if (rst_n) for (int d = 0; d < ND; d++) model_update(d);
    #1;
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < ND; d++) begin
      incv[d] = '0; flushv[d] = '0; lenv[d] = '0; clrv[d] = 1'b0;
    end
  endtask

  task automatic set_len(input int d, input int c, input int v);
    lenv[d][c*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  typedef struct {
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] flush;
    logic              clr;
    logic [NUM_CH-1:0] e_empty;
    logic [NUM_CH-1:0] e_tail;
    logic [NUM_CH-1:0] e_end;
    logic [LEN_W-1:0]  e_cnt0;
    logic [LEN_W-1:0]  e_cnt1;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Fixed-length instance; expectations are the outputs seen in the row's cycle.
    vecs[0]  = '{5'b00000, 5'b00000, 1'b0, 5'b11111, 5'b00000, 5'b00000, 3'd0, 3'd0};
    vecs[1]  = '{5'b00001, 5'b00000, 1'b0, 5'b11111, 5'b00000, 5'b00000, 3'd0, 3'd0};
    vecs[2]  = '{5'b00001, 5'b00000, 1'b0, 5'b11110, 5'b00000, 5'b00000, 3'd1, 3'd0};
    vecs[3]  = '{5'b00001, 5'b00000, 1'b0, 5'b11110, 5'b00000, 5'b00000, 3'd2, 3'd0};
    vecs[4]  = '{5'b00001, 5'b00000, 1'b0, 5'b11110, 5'b00001, 5'b00000, 3'd3, 3'd0};
    vecs[5]  = '{5'b00000, 5'b00000, 1'b0, 5'b11111, 5'b00000, 5'b00001, 3'd0, 3'd0};
    vecs[6]  = '{5'b00010, 5'b00000, 1'b0, 5'b11111, 5'b00000, 5'b00000, 3'd0, 3'd0};
    vecs[7]  = '{5'b00010, 5'b00000, 1'b0, 5'b11101, 5'b00000, 5'b00000, 3'd0, 3'd1};
    vecs[8]  = '{5'b00010, 5'b00010, 1'b0, 5'b11101, 5'b00000, 5'b00000, 3'd0, 3'd2};
    vecs[9]  = '{5'b00000, 5'b00000, 1'b0, 5'b11111, 5'b00000, 5'b00000, 3'd0, 3'd0};
    vecs[10] = '{5'b00010, 5'b00010, 1'b0, 5'b11111, 5'b00000, 5'b00000, 3'd0, 3'd0};
    vecs[11] = '{5'b00000, 5'b00000, 1'b1, 5'b11111, 5'b00000, 5'b00000, 3'd0, 3'd0};
    vecs[12] = '{5'b11111, 5'b00000, 1'b0, 5'b11111, 5'b00000, 5'b00000, 3'd0, 3'd0};
    vecs[13] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd1, 3'd1};

    idle_inputs();
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty_fix", 32'(f_empty), 32'h1f);
    chk("reset_empty_var", 32'(v_empty), 32'h1f);
    chk("reset_end_var",   32'(v_end),   32'h0);
    chk("reset_cnt_fix",   32'(f_cnt),   32'h0);
    check_all();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      idle_inputs();
      incv[0] = vecs[i].inc; flushv[0] = vecs[i].flush; clrv[0] = vecs[i].clr;
      #2;
      chk($sformatf("vec%0d_empty", i), 32'(f_empty), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_tail", i),  32'(f_tail),  32'(vecs[i].e_tail));
      chk($sformatf("vec%0d_end", i),   32'(f_end),   32'(vecs[i].e_end));
      chk($sformatf("vec%0d_cnt0", i),  32'(f_cnt[0 +: LEN_W]),     32'(vecs[i].e_cnt0));
      chk($sformatf("vec%0d_cnt1", i),  32'(f_cnt[LEN_W +: LEN_W]), 32'(vecs[i].e_cnt1));
      cycle();
    end
    idle_inputs();
    flushv[0] = '1; flushv[1] = '1;
    cycle();

    // Header length 6 on channel 2, then a single-flit packet.
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      incv[1][2] = 1'b1;
      set_len(1, 2, (i == 0) ? 6 : int'($urandom_range(0, 7)));
      #1;
      if (i == 5) chk("len6_tail", 32'(v_tail[2]), 32'd1);
      if (i == 4) chk("len6_cnt4", 32'(v_cnt[2*LEN_W +: LEN_W]), 32'd4);
      cycle();
    end
    idle_inputs();
    incv[1][2] = 1'b1;
    set_len(1, 2, 1);
    #1;
    chk("len6_end",  32'(v_end[2]), 32'd1);
    chk("len1_tail", 32'(v_tail[2]), 32'd1);
    cycle();
    idle_inputs();
    #1;
    chk("len1_end",   32'(v_end[2]), 32'd1);
    chk("len1_empty", 32'(v_empty[2]), 32'd1);
    cycle();
    #1;
    chk("len1_end_once", 32'(v_end[2]), 32'd0);
    cycle();

    // Zero header length on channel 3: one flit, sticky error, clear, clear-vs-set.
    incv[1][3] = 1'b1;
    #1;
    chk("len0_tail", 32'(v_tail[3]), 32'd1);
    cycle();
    idle_inputs();
    #1;
    chk("len0_end", 32'(v_end[3]), 32'd1);
    chk("len0_err", 32'(v_err), 32'h08);
    repeat (3) cycle();
    chk("len0_err_held", 32'(v_err[3]), 32'd1);
    clrv[1] = 1'b1;
    cycle();
    idle_inputs();
    #1;
    chk("err_cleared", 32'(v_err[3]), 32'd0);
    incv[1][3] = 1'b1;
    clrv[1] = 1'b1;
    cycle();
    idle_inputs();
    #1;
    chk("err_set_wins", 32'(v_err[3]), 32'd1);
    clrv[1] = 1'b1;
    cycle();
    idle_inputs();

    // Random traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < ND; d++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          incv[d][c]   = ($urandom_range(0, 9) < 7);
          flushv[d][c] = ($urandom_range(0, 19) == 0);
          set_len(d, c, ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 7)));
        end
        clrv[d] = ($urandom_range(0, 15) == 0);
      end
      cycle();
    end

    // Staggered starts on every channel, then reset mid-packet.
    idle_inputs();
    flushv[0] = '1; flushv[1] = '1;
    cycle();
    idle_inputs();
    for (int k = 0; k < 6; k++) begin
      for (int d = 0; d < ND; d++) begin
        if (k < int'(NUM_CH)) incv[d][k] = 1'b1;
        for (int c = 0; c < NUM_CH; c++) set_len(d, c, 7);
      end
      cycle();
    end
    chk("stagger_cnt_var", 32'(v_cnt), {17'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6});
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_empty_fix", 32'(f_empty), 32'h1f);
    chk("midrst_empty_var", 32'(v_empty), 32'h1f);
    chk("midrst_cnt_var",   32'(v_cnt),   32'h0);
    chk("midrst_end_fix",   32'(f_end),   32'h0);
    cycle();
    rst_n = 1'b1;
    idle_inputs();
    repeat (3) cycle();
    chk("postrst_end_var", 32'(v_end), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
